// File: rtl/display_reg_writer_pkg.sv
// Shared constants and types for the display register writer: register map, widths, FSM states.
package display_regs_pkg;

    localparam int unsigned NUM_REGS     = 15;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ADDR_W       = 4;
    localparam int unsigned FRAME_CNT_W  = 16;
    localparam int unsigned STATUS_PAD_W = DATA_W - FRAME_CNT_W - 1;
    localparam int unsigned COMMIT_BIT   = 0;

    localparam logic [ADDR_W-1:0] IDX_PIPE1X         = 4'd0;
    localparam logic [ADDR_W-1:0] IDX_PIPE2X         = 4'd1;
    localparam logic [ADDR_W-1:0] IDX_PIPE3X         = 4'd2;
    localparam logic [ADDR_W-1:0] IDX_PIPE4X         = 4'd3;
    localparam logic [ADDR_W-1:0] IDX_PIPE1BOTTOMTOP = 4'd4;
    localparam logic [ADDR_W-1:0] IDX_PIPE2BOTTOMTOP = 4'd5;
    localparam logic [ADDR_W-1:0] IDX_PIPE3BOTTOMTOP = 4'd6;
    localparam logic [ADDR_W-1:0] IDX_PIPE4BOTTOMTOP = 4'd7;
    localparam logic [ADDR_W-1:0] IDX_PIPE1YSPACE    = 4'd8;
    localparam logic [ADDR_W-1:0] IDX_PIPE2YSPACE    = 4'd9;
    localparam logic [ADDR_W-1:0] IDX_PIPE3YSPACE    = 4'd10;
    localparam logic [ADDR_W-1:0] IDX_PIPE4YSPACE    = 4'd11;
    localparam logic [ADDR_W-1:0] IDX_BIRD_TOP_LEFT  = 4'd12;
    localparam logic [ADDR_W-1:0] IDX_CURRENT_SCORE  = 4'd13;
    localparam logic [ADDR_W-1:0] IDX_HIGH_SCORE     = 4'd14;
    localparam logic [ADDR_W-1:0] IDX_CTRL           = 4'd15;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

endpackage

// File: rtl/display_reg_writer_if.sv
// Processor-side store/read-back bus of the display register writer.
interface display_reg_writer_if;
    import display_regs_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (output wr_en, output wr_addr, output wr_data, output rd_addr, input rd_data);
    modport slave  (input wr_en, input wr_addr, input wr_data, input rd_addr, output rd_data);
endinterface

// File: rtl/display_reg_writer_shadow_bank.sv
// Shadow register array: one write port, one registered read port with a status word in the CTRL slot.
module shadow_bank
    import display_regs_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] status_word,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] shadow [NUM_REGS]
);

    // Reads sample the array before this edge's write, so a same-cycle read returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                shadow[wr_addr] <= wr_data;
            end
            if (rd_addr < ADDR_W'(NUM_REGS)) begin
                rd_data <= shadow[rd_addr];
            end else begin
                rd_data <= status_word;
            end
        end
    end

endmodule

// File: rtl/display_reg_writer.sv
// Display register writer: shadow bank, frame-synchronous commit FSM, live registers and frame counter.
module display_reg_writer
    import display_regs_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    display_reg_writer_if.slave    bus,
    input  logic                   frame_end,
    output logic                   commit_pending,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [DATA_W-1:0]      pipe1x,
    output logic [DATA_W-1:0]      pipe2x,
    output logic [DATA_W-1:0]      pipe3x,
    output logic [DATA_W-1:0]      pipe4x,
    output logic [DATA_W-1:0]      pipe1bottomtop,
    output logic [DATA_W-1:0]      pipe2bottomtop,
    output logic [DATA_W-1:0]      pipe3bottomtop,
    output logic [DATA_W-1:0]      pipe4bottomtop,
    output logic [DATA_W-1:0]      pipe1yspace,
    output logic [DATA_W-1:0]      pipe2yspace,
    output logic [DATA_W-1:0]      pipe3yspace,
    output logic [DATA_W-1:0]      pipe4yspace,
    output logic [DATA_W-1:0]      bird_top_left,
    output logic [DATA_W-1:0]      current_score,
    output logic [DATA_W-1:0]      high_score
);

    state_e                 state_q, state_d;
    logic                   copy_c;
    logic                   commit_wr_c;
    logic                   bank_we_c;
    logic                   frame_done_q;
    logic [FRAME_CNT_W-1:0] frame_count_q;
    logic [DATA_W-1:0]      status_word_c;
    logic [DATA_W-1:0]      shadow [NUM_REGS];
    logic [DATA_W-1:0]      live_q [NUM_REGS];

    assign bank_we_c     = bus.wr_en && (bus.wr_addr < ADDR_W'(NUM_REGS));
    assign commit_wr_c   = bus.wr_en && (bus.wr_addr == IDX_CTRL) && bus.wr_data[COMMIT_BIT];
    assign status_word_c = {frame_count_q, STATUS_PAD_W'(0), commit_pending};

    shadow_bank u_shadow_bank (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (bank_we_c),
        .wr_addr     (bus.wr_addr),
        .wr_data     (bus.wr_data),
        .rd_addr     (bus.rd_addr),
        .status_word (status_word_c),
        .rd_data     (bus.rd_data),
        .shadow      (shadow)
    );

    // State register, live bank, done pulse and frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                live_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            frame_done_q <= copy_c;
            if (frame_end) begin
                frame_count_q <= frame_count_q + FRAME_CNT_W'(1);
            end
            if (copy_c) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    live_q[i] <= shadow[i];
                end
            end
        end
    end

    // A commit is consumed only by a frame_end seen while already armed; re-arms are not queued.
    always_comb begin
        state_d = state_q;
        copy_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit_wr_c) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (frame_end) begin
                    copy_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign commit_pending = (state_q == ARMED);
    assign frame_done     = frame_done_q;
    assign frame_count    = frame_count_q;

    assign pipe1x         = live_q[IDX_PIPE1X];
    assign pipe2x         = live_q[IDX_PIPE2X];
    assign pipe3x         = live_q[IDX_PIPE3X];
    assign pipe4x         = live_q[IDX_PIPE4X];
    assign pipe1bottomtop = live_q[IDX_PIPE1BOTTOMTOP];
    assign pipe2bottomtop = live_q[IDX_PIPE2BOTTOMTOP];
    assign pipe3bottomtop = live_q[IDX_PIPE3BOTTOMTOP];
    assign pipe4bottomtop = live_q[IDX_PIPE4BOTTOMTOP];
    assign pipe1yspace    = live_q[IDX_PIPE1YSPACE];
    assign pipe2yspace    = live_q[IDX_PIPE2YSPACE];
    assign pipe3yspace    = live_q[IDX_PIPE3YSPACE];
    assign pipe4yspace    = live_q[IDX_PIPE4YSPACE];
    assign bird_top_left  = live_q[IDX_BIRD_TOP_LEFT];
    assign current_score  = live_q[IDX_CURRENT_SCORE];
    assign high_score     = live_q[IDX_HIGH_SCORE];

endmodule

// File: tb/tb_display_reg_writer.sv
// Directed bench for display_reg_writer: vector table plus hand-written commit/reset/wrap sequences.
module tb_display_reg_writer;
    import display_regs_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_end;
    logic        commit_pending;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [31:0] pipe1x, pipe2x, pipe3x, pipe4x;
    logic [31:0] pipe1bottomtop, pipe2bottomtop, pipe3bottomtop, pipe4bottomtop;
    logic [31:0] pipe1yspace, pipe2yspace, pipe3yspace, pipe4yspace;
    logic [31:0] bird_top_left, current_score, high_score;
    logic [31:0] live_w [15];

    int n_checks = 0;
    int n_fail   = 0;

    display_reg_writer_if bus();

    display_reg_writer dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .frame_end      (frame_end),
        .commit_pending (commit_pending),
        .frame_done     (frame_done),
        .frame_count    (frame_count),
        .pipe1x         (pipe1x),
        .pipe2x         (pipe2x),
        .pipe3x         (pipe3x),
        .pipe4x         (pipe4x),
        .pipe1bottomtop (pipe1bottomtop),
        .pipe2bottomtop (pipe2bottomtop),
        .pipe3bottomtop (pipe3bottomtop),
        .pipe4bottomtop (pipe4bottomtop),
        .pipe1yspace    (pipe1yspace),
        .pipe2yspace    (pipe2yspace),
        .pipe3yspace    (pipe3yspace),
        .pipe4yspace    (pipe4yspace),
        .bird_top_left  (bird_top_left),
        .current_score  (current_score),
        .high_score     (high_score)
    );

    always #5 clk = ~clk;

    assign live_w[0]  = pipe1x;
    assign live_w[1]  = pipe2x;
    assign live_w[2]  = pipe3x;
    assign live_w[3]  = pipe4x;
    assign live_w[4]  = pipe1bottomtop;
    assign live_w[5]  = pipe2bottomtop;
    assign live_w[6]  = pipe3bottomtop;
    assign live_w[7]  = pipe4bottomtop;
    assign live_w[8]  = pipe1yspace;
    assign live_w[9]  = pipe2yspace;
    assign live_w[10] = pipe3yspace;
    assign live_w[11] = pipe4yspace;
    assign live_w[12] = bird_top_left;
    assign live_w[13] = current_score;
    assign live_w[14] = high_score;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ra;
        logic        fe;
        logic [31:0] e_pipe1x;
        logic [31:0] e_bird;
        logic [31:0] e_rd;
        logic        e_pend;
        logic        e_done;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                input logic [3:0] ra, input logic fe,
                                input logic [31:0] e_pipe1x, input logic [31:0] e_bird,
                                input logic [31:0] e_rd, input logic e_pend,
                                input logic e_done, input logic [15:0] e_cnt);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.fe = fe;
        v.e_pipe1x = e_pipe1x; v.e_bird = e_bird; v.e_rd = e_rd;
        v.e_pend = e_pend; v.e_done = e_done; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] ra, input logic fe);
        bus.wr_en   = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rd_addr = ra;
        frame_end   = fe;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] ra, input logic fe);
        drive(we, wa, wd, ra, fe);
        tick();
        drive(1'b0, 4'd0, 32'd0, ra, 1'b0);
    endtask

    task automatic check_status(input string name, input logic pend, input logic done,
                                input logic [15:0] cnt);
        check({name, ".pend"}, 32'(commit_pending), 32'(pend));
        check({name, ".done"}, 32'(frame_done), 32'(done));
        check({name, ".cnt"}, 32'(frame_count), 32'(cnt));
    endtask

    initial begin
        // Row: inputs for one edge, then expected pipe1x, bird, rd_data, pending, done, count.
        vecs[0]  = mk(1, 4'd0,  32'h1F4, 4'd0,  0, 32'h0,  32'h0,  32'h0,        0, 0, 16'd0);
        vecs[1]  = mk(1, 4'd12, 32'hC8,  4'd0,  0, 32'h0,  32'h0,  32'h1F4,      0, 0, 16'd0);
        vecs[2]  = mk(0, 4'd0,  32'h0,   4'd12, 1, 32'h0,  32'h0,  32'hC8,       0, 0, 16'd1);
        vecs[3]  = mk(0, 4'd0,  32'h0,   4'd15, 1, 32'h0,  32'h0,  32'h00010000, 0, 0, 16'd2);
        vecs[4]  = mk(1, 4'd0,  32'h64,  4'd0,  0, 32'h0,  32'h0,  32'h1F4,      0, 0, 16'd2);
        vecs[5]  = mk(1, 4'd15, 32'h1,   4'd0,  0, 32'h0,  32'h0,  32'h64,       1, 0, 16'd2);
        vecs[6]  = mk(0, 4'd0,  32'h0,   4'd15, 0, 32'h0,  32'h0,  32'h00020001, 1, 0, 16'd2);
        vecs[7]  = mk(0, 4'd0,  32'h0,   4'd0,  0, 32'h0,  32'h0,  32'h64,       1, 0, 16'd2);
        vecs[8]  = mk(0, 4'd0,  32'h0,   4'd0,  0, 32'h0,  32'h0,  32'h64,       1, 0, 16'd2);
        vecs[9]  = mk(0, 4'd0,  32'h0,   4'd0,  0, 32'h0,  32'h0,  32'h64,       1, 0, 16'd2);
        vecs[10] = mk(0, 4'd0,  32'h0,   4'd0,  1, 32'h64, 32'hC8, 32'h64,       0, 1, 16'd3);
        vecs[11] = mk(0, 4'd0,  32'h0,   4'd15, 0, 32'h64, 32'hC8, 32'h00030000, 0, 0, 16'd3);
        vecs[12] = mk(1, 4'd15, 32'h0,   4'd0,  0, 32'h64, 32'hC8, 32'h64,       0, 0, 16'd3);

        reset = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
        @(negedge clk);
        repeat (3) tick();
        for (int i = 0; i < 15; i++) begin
            check($sformatf("reset.live%0d", i), live_w[i], 32'h0);
        end
        check("reset.rd_data", bus.rd_data, 32'h0);
        check_status("reset", 1'b0, 1'b0, 16'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].fe);
            tick();
            check($sformatf("vec%0d.pipe1x", i), pipe1x, vecs[i].e_pipe1x);
            check($sformatf("vec%0d.bird", i), bird_top_left, vecs[i].e_bird);
            check($sformatf("vec%0d.rd_data", i), bus.rd_data, vecs[i].e_rd);
            check_status($sformatf("vec%0d", i), vecs[i].e_pend, vecs[i].e_done, vecs[i].e_cnt);
        end
        drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0);

        // Shadow write coincident with the copy: live takes the pre-write word.
        cycle(1, 4'd13, 32'h111, 4'd0, 0);
        cycle(1, 4'd15, 32'h1, 4'd0, 0);
        cycle(0, 4'd0, 32'h0, 4'd0, 1);
        check("seed.score", current_score, 32'h111);
        cycle(1, 4'd15, 32'h1, 4'd0, 0);
        cycle(1, 4'd13, 32'h380, 4'd0, 1);
        check("wr_copy.score", current_score, 32'h111);
        check_status("wr_copy", 1'b0, 1'b1, 16'd5);
        cycle(0, 4'd0, 32'h0, 4'd13, 0);
        check("wr_copy.readback", bus.rd_data, 32'h380);
        cycle(1, 4'd15, 32'h1, 4'd0, 0);
        cycle(0, 4'd0, 32'h0, 4'd0, 1);
        check("recommit.score", current_score, 32'h380);
        check_status("recommit", 1'b0, 1'b1, 16'd6);

        // Re-arm coincident with the copy is dropped.
        cycle(1, 4'd15, 32'h1, 4'd0, 0);
        cycle(1, 4'd15, 32'h1, 4'd0, 1);
        check_status("rearm", 1'b0, 1'b1, 16'd7);
        cycle(0, 4'd0, 32'h0, 4'd0, 1);
        check_status("rearm_lost", 1'b0, 1'b0, 16'd8);

        // Commit coincident with frame_end while idle only arms.
        cycle(1, 4'd0, 32'h77, 4'd0, 0);
        cycle(1, 4'd15, 32'h1, 4'd0, 1);
        check("idle_arm.pipe1x", pipe1x, 32'h64);
        check_status("idle_arm", 1'b1, 1'b0, 16'd9);
        cycle(0, 4'd0, 32'h0, 4'd0, 1);
        check("idle_arm_copy.pipe1x", pipe1x, 32'h77);
        check_status("idle_arm_copy", 1'b0, 1'b1, 16'd10);

        // Reset while armed drops the commit and clears all state.
        cycle(1, 4'd0, 32'hAB, 4'd0, 0);
        cycle(1, 4'd15, 32'h1, 4'd0, 0);
        check("pre_reset.pend", 32'(commit_pending), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset.pipe1x", pipe1x, 32'h0);
        check("mid_reset.rd_data", bus.rd_data, 32'h0);
        check_status("mid_reset", 1'b0, 1'b0, 16'd0);
        cycle(0, 4'd0, 32'h0, 4'd0, 1);
        check("post_reset.pipe1x", pipe1x, 32'h0);
        check("post_reset.score", current_score, 32'h0);
        check_status("post_reset", 1'b0, 1'b0, 16'd1);
        cycle(0, 4'd0, 32'h0, 4'd0, 0);
        check("post_reset.shadow0", bus.rd_data, 32'h0);

        // Frame counter wrap.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        frame_end = 1'b1;
        repeat (65535) tick();
        check("wrap.max", 32'(frame_count), 32'h0000FFFF);
        tick();
        frame_end = 1'b0;
        check("wrap.zero", 32'(frame_count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
